// File: rtl/run_length_detector_if.sv
// ---------------------------------------------------------------------------
// run_length_detector_if
//   Groups the sampling controls, channel inputs and detection results of
//   run_length_detector into one bundle.
//
//   Signals:
//     en         sample enable; when low, all detector state holds
//     clear      synchronous clear of counters and outputs; beats en
//     w          per-channel input bit                   [CHANNELS]
//     out        per-channel detect (level or pulse)     [CHANNELS]
//     any        OR of out
//     hit_count  saturating count of detections          [HIT_W]
//
//   Modports:
//     master  drives en/clear/w and observes the results (stimulus side)
//     slave   the detector itself
// ---------------------------------------------------------------------------
interface run_length_detector_if #(
   parameter int CHANNELS = 4,
   parameter int HIT_W    = 8
);
   logic                en;
   logic                clear;
   logic [CHANNELS-1:0] w;
   logic [CHANNELS-1:0] out;
   logic                any;
   logic [HIT_W-1:0]    hit_count;

   modport master (
      output en, clear, w,
      input  out, any, hit_count
   );

   modport slave (
      input  en, clear, w,
      output out, any, hit_count
   );
endinterface

// File: rtl/run_length_detector.sv
// ---------------------------------------------------------------------------
// run_length_detector
//   Multi-channel run detector. Each channel owns a saturating counter of
//   consecutive enabled high samples; a channel is detected once that count
//   reaches RUN_LEN. The output is either the level decode of the counter
//   (MODE=0) or a registered one-cycle pulse per run (MODE=1). A saturating
//   hit counter accumulates detections across all channels.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; clears every register
//     bus    run_length_detector_if.slave:
//              en, clear, w      inputs
//              out, any, hit_count outputs (all driven from registers only)
// ---------------------------------------------------------------------------
module run_length_detector #(
   parameter int CHANNELS = 4,
   parameter int RUN_LEN  = 2,
   parameter bit MODE     = 1'b0,
   parameter int HIT_W    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   run_length_detector_if.slave  bus
);
   localparam int CNT_W = $clog2(RUN_LEN + 1);
   // Wide enough to hold the hit counter plus one increment per channel.
   localparam int SUM_W = HIT_W + $clog2(CHANNELS + 1);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RUN_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_LEN - 1);
   localparam logic [HIT_W-1:0] HIT_MAX  = {HIT_W{1'b1}};

   logic [CHANNELS-1:0] level;
   logic [CHANNELS-1:0] pulse_reg;
   logic [CHANNELS-1:0] pulse_next;
   logic [HIT_W-1:0]    hit_reg;
   logic [HIT_W-1:0]    hit_next;
   logic [SUM_W-1:0]    sum_next;
   logic [CHANNELS-1:0] out_sel;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;

         always_comb begin
            cnt_next = cnt_reg;
            if (bus.clear) begin
               cnt_next = '0;
            end else if (bus.en) begin
               if (!bus.w[gi]) begin
                  cnt_next = '0;
               end else if (cnt_reg != CNT_FULL) begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_next;
            end
         end

         assign level[gi] = (cnt_reg == CNT_FULL);
         // The sample that lifts the counter from RUN_LEN-1 to RUN_LEN is the
         // single detecting sample of a run; saturation prevents a repeat.
         assign pulse_next[gi] = bus.en & ~bus.clear & bus.w[gi] &
                                 (cnt_reg == CNT_LAST);
      end
   endgenerate

   // Hit counter adds every channel that detects this edge, clamped at max.
   always_comb begin
      sum_next = SUM_W'(hit_reg);
      for (int i = 0; i < CHANNELS; i++) begin
         sum_next = sum_next + SUM_W'(pulse_next[i]);
      end
      hit_next = hit_reg;
      if (bus.clear) begin
         hit_next = '0;
      end else if (sum_next > SUM_W'(HIT_MAX)) begin
         hit_next = HIT_MAX;
      end else begin
         hit_next = sum_next[HIT_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pulse_reg <= '0;
         hit_reg   <= '0;
      end else begin
         pulse_reg <= pulse_next;
         hit_reg   <= hit_next;
      end
   end

   assign out_sel       = MODE ? pulse_reg : level;
   assign bus.out       = out_sel;
   assign bus.any       = |out_sel;
   assign bus.hit_count = hit_reg;
endmodule

// File: tb/tb_run_length_detector.sv
// ---------------------------------------------------------------------------
// tb_run_length_detector
//   Three detectors share one stimulus stream: level output (HIT_W=8),
//   pulse output (HIT_W=8) and level output with a 2-bit hit counter.
//   The driver pushes the expected post-edge outputs into a queue; a monitor
//   pops one entry after each rising edge and compares all three detectors.
//   The reference model tracks the unbounded length of each channel's
//   current enabled run and the unbounded number of detections.
// ---------------------------------------------------------------------------
module tb_run_length_detector;
   localparam int CH = 4;
   localparam int RL = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   run_length_detector_if #(.CHANNELS(CH), .HIT_W(8)) bus_lvl ();
   run_length_detector_if #(.CHANNELS(CH), .HIT_W(8)) bus_pls ();
   run_length_detector_if #(.CHANNELS(CH), .HIT_W(2)) bus_sat ();

   run_length_detector #(.CHANNELS(CH), .RUN_LEN(RL), .MODE(1'b0), .HIT_W(8)) dut_lvl (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_lvl)
   );
   run_length_detector #(.CHANNELS(CH), .RUN_LEN(RL), .MODE(1'b1), .HIT_W(8)) dut_pls (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_pls)
   );
   run_length_detector #(.CHANNELS(CH), .RUN_LEN(RL), .MODE(1'b0), .HIT_W(2)) dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_sat)
   );

   typedef struct {
      logic [CH-1:0] level;
      logic [CH-1:0] pulse;
      int            hits;
   } exp_t;

   exp_t exp_q[$];
   int   run_len [CH];
   int   total_hits;
   int   total_cmp = 0;
   int   bad_cmp   = 0;
   int   txn       = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cmp++;
      if (act !== req) begin
         bad_cmp++;
         $display("FAIL %s: got %0h, wanted %0h", name, act, req);
      end
   endtask

   function automatic int sat(input int v, input int bits);
      int top;
      top = (1 << bits) - 1;
      return (v > top) ? top : v;
   endfunction

   task automatic drive(input bit e, input bit c, input logic [CH-1:0] wv);
      bus_lvl.en = e; bus_lvl.clear = c; bus_lvl.w = wv;
      bus_pls.en = e; bus_pls.clear = c; bus_pls.w = wv;
      bus_sat.en = e; bus_sat.clear = c; bus_sat.w = wv;
   endtask

   // Predict the outputs after the coming rising edge.
   task automatic model_apply(input bit r, input bit e, input bit c, input logic [CH-1:0] wv);
      exp_t x;
      for (int i = 0; i < CH; i++) begin
         x.pulse[i] = 1'b0;
         if (r || c) begin
            run_len[i] = 0;
         end else if (e) begin
            if (wv[i]) begin
               run_len[i]++;
               x.pulse[i] = (run_len[i] == RL);
            end else begin
               run_len[i] = 0;
            end
         end
         x.level[i] = (run_len[i] >= RL);
      end
      if (r || c) total_hits = 0;
      else        total_hits += $countones(x.pulse);
      x.hits = total_hits;
      exp_q.push_back(x);
   endtask

   task automatic step(input bit r, input bit e, input bit c, input logic [CH-1:0] wv);
      @(negedge clk);
      reset = r;
      drive(e, c, wv);
      model_apply(r, e, c, wv);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " lvl.out"},  32'(bus_lvl.out),       32'd0);
      check({tag, " lvl.any"},  32'(bus_lvl.any),       32'd0);
      check({tag, " lvl.hits"}, 32'(bus_lvl.hit_count), 32'd0);
      check({tag, " pls.out"},  32'(bus_pls.out),       32'd0);
      check({tag, " sat.hits"}, 32'(bus_sat.hit_count), 32'd0);
   endtask

   // Monitor: one expected entry per rising edge that the driver scheduled.
   exp_t m;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            txn++;
            check("lvl.out",  32'(bus_lvl.out),       32'(m.level));
            check("lvl.any",  32'(bus_lvl.any),       32'(|m.level));
            check("lvl.hits", 32'(bus_lvl.hit_count), 32'(sat(m.hits, 8)));
            check("pls.out",  32'(bus_pls.out),       32'(m.pulse));
            check("pls.any",  32'(bus_pls.any),       32'(|m.pulse));
            check("pls.hits", 32'(bus_pls.hit_count), 32'(sat(m.hits, 8)));
            check("sat.out",  32'(bus_sat.out),       32'(m.level));
            check("sat.hits", 32'(bus_sat.hit_count), 32'(sat(m.hits, 2)));
            $display("txn %0d: lvl=%h pls=%h hits=%0d sat_hits=%0d",
                     txn, bus_lvl.out, bus_pls.out, bus_lvl.hit_count, bus_sat.hit_count);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, wanted completion");
      $fatal(1, "watchdog expired");
   end

   bit seq1 [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      logic [CH-1:0] wv;
      bit            e;
      bit            c;

      drive(1'b0, 1'b0, '0);
      for (int i = 0; i < CH; i++) run_len[i] = 0;
      total_hits = 0;
      #1;
      check_all_zero("reset at start");
      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, '0);

      // Channel 0 pattern: detection after samples 6..8, drop after 9.
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, {3'b000, seq1[i]});

      // Channel 1: long run then short run, two pulses.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 4'b0010);
      step(1'b0, 1'b1, 1'b0, 4'b0000);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 4'b0010);
      step(1'b0, 1'b1, 1'b0, 4'b0000);

      // All channels detect on the same edge.
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 4'b1111);
      step(1'b0, 1'b1, 1'b0, 4'b0000);

      // Channel 2 run paused by en, resumed afterwards.
      step(1'b0, 1'b1, 1'b0, 4'b0100);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'b0100);
      step(1'b0, 1'b1, 1'b0, 4'b0100);
      step(1'b0, 1'b1, 1'b0, 4'b0000);

      // Five more detections on channel 0, then clear wins over en.
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b0, 4'b0001);
         step(1'b0, 1'b1, 1'b0, 4'b0001);
         step(1'b0, 1'b1, 1'b0, 4'b0000);
      end
      step(1'b0, 1'b1, 1'b0, 4'b1111);
      step(1'b0, 1'b1, 1'b1, 4'b1111);
      step(1'b0, 1'b1, 1'b0, 4'b1111);
      step(1'b0, 1'b1, 1'b0, 4'b0000);

      // Randomised traffic.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < CH; i++) wv[i] = ($urandom_range(9, 0) < 7);
         e = ($urandom_range(99, 0) < 85);
         c = ($urandom_range(99, 0) < 3);
         step(1'b0, e, c, wv);
      end

      // Asynchronous reset between edges while every channel is detected.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'b1111);
      @(negedge clk);
      check("pre-reset lvl.out", 32'(bus_lvl.out), 32'hF);
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("async reset");
      step(1'b1, 1'b1, 1'b0, 4'b1111);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 4'b1111);
      step(1'b0, 1'b1, 1'b0, 4'b0000);

      repeat (3) @(negedge clk);
      check("queue drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total_cmp, bad_cmp);
      $finish;
   end
endmodule
